// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired multi-cycle control unit for the bus-based CPU
//               datapath: fetch, memory wait, decode, reg-reg ALU execute.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    input  logic        stop_req,
    output logic [15:0] Rin_sel,
    output logic [15:0] Rout_sel,
    output logic        PCin,
    output logic        PCout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        IncPC,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        Read,
    output logic [12:0] alu_op,
    output logic        run,
    output logic        fault,
    output logic [31:0] instr_count
);

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH0     = 5'd1,
        S_FETCH1     = 5'd2,
        S_FETCH_WAIT = 5'd3,
        S_FETCH2     = 5'd4,
        S_DECODE     = 5'd5,
        S_A0         = 5'd6,
        S_A1         = 5'd7,
        S_A2         = 5'd8,
        S_M0         = 5'd9,
        S_M1         = 5'd10,
        S_M2         = 5'd11,
        S_M3         = 5'd12,
        S_N0         = 5'd13,
        S_N1         = 5'd14,
        S_RETIRE     = 5'd15,
        S_HALT       = 5'd16
    } state_t;

    localparam logic [2:0] C_CLS_ALU  = 3'd0;
    localparam logic [2:0] C_CLS_MD   = 3'd1;
    localparam logic [2:0] C_CLS_NN   = 3'd2;
    localparam logic [2:0] C_CLS_NOP  = 3'd3;
    localparam logic [2:0] C_CLS_HALT = 3'd4;
    localparam logic [2:0] C_CLS_ILL  = 3'd5;

    localparam logic [12:0] C_ALU_AND  = 13'h0001;
    localparam logic [12:0] C_ALU_OR   = 13'h0002;
    localparam logic [12:0] C_ALU_NEG  = 13'h0004;
    localparam logic [12:0] C_ALU_NOT  = 13'h0008;
    localparam logic [12:0] C_ALU_SUB  = 13'h0010;
    localparam logic [12:0] C_ALU_ADD  = 13'h0020;
    localparam logic [12:0] C_ALU_MUL  = 13'h0040;
    localparam logic [12:0] C_ALU_ROR  = 13'h0080;
    localparam logic [12:0] C_ALU_DIV  = 13'h0100;
    localparam logic [12:0] C_ALU_SHL  = 13'h0200;
    localparam logic [12:0] C_ALU_SHR  = 13'h0400;
    localparam logic [12:0] C_ALU_SHRA = 13'h0800;
    localparam logic [12:0] C_ALU_ROL  = 13'h1000;

    // Counter wide enough to hold MEM_TIMEOUT itself without wrapping
    localparam int unsigned     C_TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [C_TW-1:0] C_TO = C_TW'(MEM_TIMEOUT);

    state_t          r_state_q, w_state_d;
    logic            r_fault_q, w_fault_d;
    logic [31:0]     r_cnt_q,   w_cnt_d;
    logic [C_TW-1:0] r_tcnt_q,  w_tcnt_d;
    logic [C_TW-1:0] w_tcnt_inc;

    logic [4:0]  w_opcode;
    logic [15:0] w_ra_hot, w_rb_hot, w_rc_hot;
    logic [2:0]  w_cls;
    logic [12:0] w_alu;
    logic        w_unused_ir;

    assign w_opcode    = IR[31:27];
    assign w_ra_hot    = 16'd1 << IR[26:23];
    assign w_rb_hot    = 16'd1 << IR[22:19];
    assign w_rc_hot    = 16'd1 << IR[18:15];
    assign w_unused_ir = ^IR[14:0];
    assign w_tcnt_inc  = r_tcnt_q + 1'b1;

    always_comb begin
        w_cls = C_CLS_ILL;
        w_alu = 13'd0;
        case (w_opcode)
            5'b00011: begin w_cls = C_CLS_ALU;  w_alu = C_ALU_ADD;  end
            5'b00100: begin w_cls = C_CLS_ALU;  w_alu = C_ALU_SUB;  end
            5'b00101: begin w_cls = C_CLS_ALU;  w_alu = C_ALU_AND;  end
            5'b00110: begin w_cls = C_CLS_ALU;  w_alu = C_ALU_OR;   end
            5'b00111: begin w_cls = C_CLS_ALU;  w_alu = C_ALU_ROR;  end
            5'b01000: begin w_cls = C_CLS_ALU;  w_alu = C_ALU_ROL;  end
            5'b01001: begin w_cls = C_CLS_ALU;  w_alu = C_ALU_SHR;  end
            5'b01010: begin w_cls = C_CLS_ALU;  w_alu = C_ALU_SHRA; end
            5'b01011: begin w_cls = C_CLS_ALU;  w_alu = C_ALU_SHL;  end
            5'b01111: begin w_cls = C_CLS_MD;   w_alu = C_ALU_DIV;  end
            5'b10000: begin w_cls = C_CLS_MD;   w_alu = C_ALU_MUL;  end
            5'b10001: begin w_cls = C_CLS_NN;   w_alu = C_ALU_NEG;  end
            5'b10010: begin w_cls = C_CLS_NN;   w_alu = C_ALU_NOT;  end
            5'b11010: begin w_cls = C_CLS_NOP;  end
            5'b11011: begin w_cls = C_CLS_HALT; end
            default:  begin w_cls = C_CLS_ILL;  end
        endcase
    end

    always_comb begin
        w_state_d = r_state_q;
        w_fault_d = r_fault_q;
        w_cnt_d   = r_cnt_q;
        w_tcnt_d  = '0;
        case (r_state_q)
            S_RESET:  w_state_d = S_FETCH0;
            S_FETCH0: w_state_d = S_FETCH1;
            S_FETCH1: w_state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (mem_ready) begin
                    w_state_d = S_FETCH2;
                end else if ((MEM_TIMEOUT != 0) && (w_tcnt_inc == C_TO)) begin
                    w_state_d = S_HALT;
                    w_fault_d = 1'b1;
                end else begin
                    w_tcnt_d  = w_tcnt_inc;
                end
            end
            S_FETCH2: w_state_d = S_DECODE;
            S_DECODE: begin
                case (w_cls)
                    C_CLS_ALU:  w_state_d = S_A0;
                    C_CLS_MD:   w_state_d = S_M0;
                    C_CLS_NN:   w_state_d = S_N0;
                    C_CLS_NOP:  w_state_d = S_RETIRE;
                    C_CLS_HALT: w_state_d = S_HALT;
                    default: begin
                        w_state_d = S_HALT;
                        w_fault_d = 1'b1;
                    end
                endcase
            end
            S_A0:     w_state_d = S_A1;
            S_A1:     w_state_d = S_A2;
            S_A2:     w_state_d = S_RETIRE;
            S_M0:     w_state_d = S_M1;
            S_M1:     w_state_d = S_M2;
            S_M2:     w_state_d = S_M3;
            S_M3:     w_state_d = S_RETIRE;
            S_N0:     w_state_d = S_N1;
            S_N1:     w_state_d = S_RETIRE;
            S_RETIRE: begin
                w_cnt_d   = r_cnt_q + 32'd1;
                w_state_d = stop_req ? S_HALT : S_FETCH0;
            end
            S_HALT:   w_state_d = S_HALT;
            default:  w_state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state_q <= S_RESET;
            r_fault_q <= 1'b0;
            r_cnt_q   <= 32'd0;
            r_tcnt_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_fault_q <= w_fault_d;
            r_cnt_q   <= w_cnt_d;
            r_tcnt_q  <= w_tcnt_d;
        end
    end

    // Strobes decode from state and IR only, so clr clears them immediately
    always_comb begin
        Rin_sel  = 16'd0;
        Rout_sel = 16'd0;
        alu_op   = 13'd0;
        PCin     = 1'b0;
        PCout    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        HIin     = 1'b0;
        HIout    = 1'b0;
        LOin     = 1'b0;
        LOout    = 1'b0;
        IncPC    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        Read     = 1'b0;
        case (r_state_q)
            S_FETCH0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_FETCH1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
            end
            S_FETCH_WAIT: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_FETCH2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_A0: begin
                Rout_sel = w_rb_hot;
                Yin      = 1'b1;
            end
            S_A1: begin
                Rout_sel = w_rc_hot;
                alu_op   = w_alu;
                Zin      = 1'b1;
            end
            S_A2, S_N1: begin
                Zlowout = 1'b1;
                Rin_sel = w_ra_hot;
            end
            S_M0: begin
                Rout_sel = w_ra_hot;
                Yin      = 1'b1;
            end
            S_M1, S_N0: begin
                Rout_sel = w_rb_hot;
                alu_op   = w_alu;
                Zin      = 1'b1;
            end
            S_M2: begin
                Zlowout = 1'b1;
                LOin    = 1'b1;
            end
            S_M3: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign run         = (r_state_q != S_RESET) && (r_state_q != S_HALT);
    assign fault       = r_fault_q;
    assign instr_count = r_cnt_q;

endmodule
`default_nettype wire
